cacheline_adapter: RTL and testbench

//   Responder end of the cache DFP interface. Accepts one 256-bit line read or write from the cache
//   (dfp_read/dfp_write, dfp_addr, dfp_wdata), returns dfp_rdata and a one-cycle dfp_resp.

---
 rtl/cache_types.sv | 16 +
 rtl/cacheline_adapter.sv | 133 +++++++++++++
 tb/tb_cacheline_adapter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared cache-side types and constants for the DFP-to-bmem line adapter.
package cache_types;

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    RD_CMD,
    RD_DATA,
    RESP
  } cla_state_t;

  localparam int CLA_BEAT_W     = 64;
  localparam int CLA_BURST_LEN  = 4;
  localparam int CLA_LINE_OFS_W = 5;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit cache line request into a 4-beat x 64-bit bmem burst.
// Define CLA_RADDR_CHECK_EN to drop read beats whose bmem_raddr mismatches and flag cla_err.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int BEAT_W    = CLA_BEAT_W,
  parameter int BURST_LEN = CLA_BURST_LEN,
  parameter int ADDR_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              dfp_addr,
  input  logic                           dfp_read,
  input  logic                           dfp_write,
  input  logic [CLA_BEAT_W*CLA_BURST_LEN-1:0] dfp_wdata,
  output logic [CLA_BEAT_W*CLA_BURST_LEN-1:0] dfp_rdata,
  output logic                           dfp_resp,
  output logic [ADDR_W-1:0]              bmem_addr,
  output logic                           bmem_read,
  output logic                           bmem_write,
  output logic [BEAT_W-1:0]              bmem_wdata,
  input  logic                           bmem_ready,
  input  logic [ADDR_W-1:0]              bmem_raddr,
  input  logic [BEAT_W-1:0]              bmem_rdata,
`ifdef CLA_RADDR_CHECK_EN
  input  logic                           bmem_rvalid,
  output logic                           cla_err
`else
  input  logic                           bmem_rvalid
`endif
);

  localparam int LINE_W  = BEAT_W * BURST_LEN;
  localparam int BEAT_SH = $clog2(BEAT_W);

  cla_state_t        state;
  logic [1:0]        cnt;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rbuf;
  logic [LINE_W-1:0] rbuf_next;
  logic              beat_ok;
  logic              unused_bits;

`ifdef CLA_RADDR_CHECK_EN
  logic beat_bad;
  assign beat_ok     = bmem_rvalid && (bmem_raddr == bmem_addr);
  assign beat_bad    = bmem_rvalid && (bmem_raddr != bmem_addr);
  assign unused_bits = ^{dfp_addr[CLA_LINE_OFS_W-1:0], wline[BEAT_W-1:0]};
`else
  assign beat_ok     = bmem_rvalid;
  assign unused_bits = ^{dfp_addr[CLA_LINE_OFS_W-1:0], wline[BEAT_W-1:0], bmem_raddr};
`endif

  // Line buffer with the incoming beat merged, so the final beat can go straight to dfp_rdata.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{cnt, {BEAT_SH{1'b0}}} +: BEAT_W] = bmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      wline      <= '0;
      rbuf       <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
`ifdef CLA_RADDR_CHECK_EN
      cla_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dfp_write) begin
            wline      <= dfp_wdata;
            bmem_addr  <= {dfp_addr[ADDR_W-1:CLA_LINE_OFS_W], {CLA_LINE_OFS_W{1'b0}}};
            bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            bmem_write <= 1'b1;
            cnt        <= 2'd0;
            state      <= WR_BURST;
          end else if (dfp_read) begin
            bmem_addr  <= {dfp_addr[ADDR_W-1:CLA_LINE_OFS_W], {CLA_LINE_OFS_W{1'b0}}};
            bmem_read  <= 1'b1;
            cnt        <= 2'd0;
            state      <= RD_CMD;
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              bmem_write <= 1'b0;
              dfp_resp   <= 1'b1;
              state      <= RESP;
            end else begin
              bmem_wdata <= wline[{cnt + 2'd1, {BEAT_SH{1'b0}}} +: BEAT_W];
            end
          end
        end
        RD_CMD: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (beat_ok) begin
            rbuf <= rbuf_next;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              dfp_rdata <= rbuf_next;
              dfp_resp  <= 1'b1;
              state     <= RESP;
            end
          end
`ifdef CLA_RADDR_CHECK_EN
          if (beat_bad) cla_err <= 1'b1;
`endif
        end
        RESP: begin
          dfp_resp <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed cases plus randomized ready/rvalid traffic.
// Honours CLA_RADDR_CHECK_EN to exercise the bmem_raddr filter and cla_err.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         cla_err_obs;

  int vectors     = 0;
  int miscompares = 0;

  logic [255:0] exp_rdata;
  logic         exp_err;

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
`ifdef CLA_RADDR_CHECK_EN
    .bmem_rvalid (bmem_rvalid),
    .cla_err     (cla_err_obs)
`else
    .bmem_rvalid (bmem_rvalid)
`endif
  );

`ifndef CLA_RADDR_CHECK_EN
  assign cla_err_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] beat_of(input logic [255:0] line, input int k);
    return 64'(line >> (k * 64));
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_resp"}, dfp_resp, 1'b0);
    checkw({tag, "_rdata"}, dfp_rdata, 256'd0);
    checkw({tag, "_baddr"}, 256'(bmem_addr), 256'd0);
    check1({tag, "_bread"}, bmem_read, 1'b0);
    check1({tag, "_bwrite"}, bmem_write, 1'b0);
    checkw({tag, "_bwdata"}, 256'(bmem_wdata), 256'd0);
    check1({tag, "_err"}, cla_err_obs, 1'b0);
  endtask

  // Drives a line write; ready is low for stall_cycles at stall_beat, optionally random elsewhere.
  task automatic applyStimulus_write(input logic [31:0] addr, input logic [255:0] line,
                                     input bit also_read, input int stall_beat,
                                     input int stall_cycles, input bit rnd);
    int k = 0;
    int stalled = 0;
    int guard = 0;
    bit rdy;
    dfp_addr  = addr;
    dfp_wdata = line;
    dfp_write = 1'b1;
    dfp_read  = also_read;
    tick();
    while (k < 4) begin
      check1("wr_bmem_write", bmem_write, 1'b1);
      check1("wr_no_bmem_read", bmem_read, 1'b0);
      checkw("wr_bmem_addr", 256'(bmem_addr), 256'(line_addr(addr)));
      checkw("wr_beat", 256'(bmem_wdata), 256'(beat_of(line, k)));
      check1("wr_no_early_resp", dfp_resp, 1'b0);
      rdy = 1'b1;
      if (k == stall_beat && stalled < stall_cycles) begin
        rdy = 1'b0;
        stalled++;
      end else if (rnd && guard < 20 && $urandom_range(0, 2) == 0) begin
        rdy = 1'b0;
      end
      guard++;
      bmem_ready = rdy;
      tick();
      if (rdy) k++;
    end
    bmem_ready = 1'b0;
    check1("wr_resp", dfp_resp, 1'b1);
    check1("wr_bmem_write_done", bmem_write, 1'b0);
    checkw("wr_rdata_unchanged", dfp_rdata, exp_rdata);
    tick();
    dfp_write = 1'b0;
    dfp_read  = 1'b0;
    check1("wr_resp_one_cycle", dfp_resp, 1'b0);
    check1("wr_err", cla_err_obs, exp_err);
  endtask

  // Drives a line read; gaps in rvalid at gap_beat and optionally random; one bad-raddr beat if bad.
  task automatic applyStimulus_read(input logic [31:0] addr, input logic [255:0] line,
                                    input int gap_beat, input int gap_cycles,
                                    input bit rnd, input bit bad);
    int k = 0;
    int gaps = 0;
    int guard = 0;
    bit v;
    bit rdy;
    bit bad_done = 1'b0;
    bit this_bad;
    dfp_addr = addr;
    dfp_read = 1'b1;
    tick();
    rdy = 1'b0;
    while (!rdy) begin
      check1("rd_bmem_read", bmem_read, 1'b1);
      check1("rd_no_bmem_write", bmem_write, 1'b0);
      checkw("rd_bmem_addr", 256'(bmem_addr), 256'(line_addr(addr)));
      rdy = !(rnd && guard < 20 && $urandom_range(0, 1) == 0);
      guard++;
      bmem_ready = rdy;
      tick();
    end
    bmem_ready = 1'b0;
    guard = 0;
    while (k < 4) begin
      check1("rd_cmd_dropped", bmem_read, 1'b0);
      check1("rd_no_early_resp", dfp_resp, 1'b0);
      v = 1'b1;
      if (k == gap_beat && gaps < gap_cycles) begin
        v = 1'b0;
        gaps++;
      end else if (rnd && guard < 20 && $urandom_range(0, 2) == 0) begin
        v = 1'b0;
      end
      guard++;
      this_bad = v && bad && !bad_done && k == 1;
      bmem_rvalid = v;
      bmem_raddr  = this_bad ? line_addr(addr) + 32'd32 : line_addr(addr);
      bmem_rdata  = this_bad ? 64'hDEAD_BEEF_0BAD_BEA7 : beat_of(line, k);
      tick();
      if (this_bad) begin
        bad_done = 1'b1;
        exp_err  = 1'b1;
      end else if (v) begin
        k++;
      end
    end
    bmem_rvalid = 1'b0;
    exp_rdata   = line;
    check1("rd_resp", dfp_resp, 1'b1);
    checkw("rd_rdata", dfp_rdata, exp_rdata);
    tick();
    dfp_read = 1'b0;
    check1("rd_resp_one_cycle", dfp_resp, 1'b0);
    checkw("rd_rdata_held", dfp_rdata, exp_rdata);
    check1("rd_err", cla_err_obs, exp_err);
  endtask

  task automatic checkOutput_reset_midread(input logic [31:0] addr);
    logic [255:0] line;
    line = rand_line();
    dfp_addr = addr;
    dfp_read = 1'b1;
    tick();
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    bmem_raddr = line_addr(addr);
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat_of(line, k);
      tick();
    end
    rst         = 1'b1;
    bmem_rdata  = beat_of(line, 2);
    tick();
    rst       = 1'b0;
    dfp_read  = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    check_reset_outputs("midread_rst");
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat_of(line, 3);
      tick();
      check1("stray_no_resp", dfp_resp, 1'b0);
      check1("stray_no_read", bmem_read, 1'b0);
      checkw("stray_rdata", dfp_rdata, 256'd0);
    end
    bmem_rvalid = 1'b0;
  endtask

  initial begin
    logic [255:0] line;
    logic [31:0]  addr;
    rst         = 1'b1;
    dfp_addr    = '0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    bmem_ready  = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;
    exp_rdata   = '0;
    exp_err     = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset_idle");

    // Directed: basic write, stalled write, gapped read, simultaneous read+write.
    line = {64'hDDDD_3333_DDDD_3333, 64'hCCCC_2222_CCCC_2222,
            64'hBBBB_1111_BBBB_1111, 64'hAAAA_0000_AAAA_0000};
    applyStimulus_write(32'h0000_1234, line, 1'b0, -1, 0, 1'b0);
    applyStimulus_write($urandom, rand_line(), 1'b0, 1, 2, 1'b0);
    line = {64'hD, 64'hC, 64'hB, 64'hA};
    applyStimulus_read(32'h0000_4567, line, 2, 3, 1'b0, 1'b0);
    applyStimulus_write(32'h0000_8888, rand_line(), 1'b1, -1, 0, 1'b0);

`ifdef CLA_RADDR_CHECK_EN
    applyStimulus_read($urandom, rand_line(), -1, 0, 1'b0, 1'b1);
    applyStimulus_write($urandom, rand_line(), 1'b0, -1, 0, 1'b1);
`endif

    checkOutput_reset_midread(32'h0000_2040);
    applyStimulus_read(32'h0000_2040, rand_line(), -1, 0, 1'b0, 1'b0);

    // Randomized mix of reads and writes with random ready/rvalid timing.
    for (int i = 0; i < 24; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 0)
        applyStimulus_write(addr, rand_line(), 1'b0, -1, 0, 1'b1);
      else
        applyStimulus_read(addr, rand_line(), -1, 0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
